// File: rtl/hv_adc_flt_chk.sv
// ---------------------------------------------------------------------------
// hv_adc_flt_chk
//
// Over/under-voltage fault checker for one HV ADC channel. Each accepted
// averaged sample is compared against programmable OV/UV trip and release
// thresholds. Trip and release both need N consecutive qualifying samples
// (N = max(i_dbc_num, 1)). The checker produces registered live fault flags
// and sticky "fault seen" bits.
//
// Optional feature, macro HV_ADC_FLT_MIN_MAX_EN:
//   When defined, the block tracks the running max/min of accepted samples.
//   i_flt_clr reloads both trackers.
//   When undefined, o_data_max is tied to 0 and o_data_min to all-ones.
//
// Sample handshake: i_adc_data is taken on a rising i_clk edge only when
// i_adc_vld is high. There is no back-pressure. Cycles without a strobe
// leave the FSM and the debounce counter unchanged.
//
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_adc_data/i_adc_vld averaged sample and its one-cycle strobe
//   i_flt_en            level enable; low forces NORM and clears live flags
//   i_ovp_th/i_ovp_rls_th  OV trip (data > th) / release (data < th)
//   i_uvp_th/i_uvp_rls_th  UV trip (data < th) / release (data > th)
//   i_dbc_num           consecutive-sample count, 0 behaves as 1
//   i_flt_clr           one-cycle pulse clearing the sticky bits (and min/max)
//   o_ovp_flt/o_uvp_flt live fault flags
//   o_ovp_sticky/o_uvp_sticky latched fault-seen bits
//   o_data_max/o_data_min running extremes (optional feature)
//
// FSM state (state_q) and debounce counter (cnt_q) are plain named flops so
// that checkers can bind to them directly.
// ---------------------------------------------------------------------------
module hv_adc_flt_chk #(
    parameter int ADC_DW = 10,
    parameter int DBC_DW = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADC_DW-1:0] i_adc_data,
    input  logic              i_adc_vld,
    input  logic              i_flt_en,
    input  logic [ADC_DW-1:0] i_ovp_th,
    input  logic [ADC_DW-1:0] i_ovp_rls_th,
    input  logic [ADC_DW-1:0] i_uvp_th,
    input  logic [ADC_DW-1:0] i_uvp_rls_th,
    input  logic [DBC_DW-1:0] i_dbc_num,
    input  logic              i_flt_clr,
    output logic              o_ovp_flt,
    output logic              o_uvp_flt,
    output logic              o_ovp_sticky,
    output logic              o_uvp_sticky,
    output logic [ADC_DW-1:0] o_data_max,
    output logic [ADC_DW-1:0] o_data_min
);

    typedef enum logic [2:0] {
        NORM    = 3'd0,
        OV_PEND = 3'd1,
        OV_FLT  = 3'd2,
        OV_RLS  = 3'd3,
        UV_PEND = 3'd4,
        UV_FLT  = 3'd5,
        UV_RLS  = 3'd6
    } state_e;

    localparam logic [DBC_DW-1:0] CNT_ONE = {{(DBC_DW-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [DBC_DW-1:0] cnt_q, cnt_d;
    logic              ovp_flt_q, ovp_flt_d;
    logic              uvp_flt_q, uvp_flt_d;
    logic              ovp_sticky_q, ovp_sticky_d;
    logic              uvp_sticky_q, uvp_sticky_d;

    logic [DBC_DW-1:0] n_req;
    logic [DBC_DW-1:0] cnt_inc;
    logic              single;
    logic              ov_hit, uv_hit, ov_rls_hit, uv_rls_hit;
    logic              ov_trip, uv_trip;

    always_comb begin
        n_req      = (i_dbc_num == '0) ? CNT_ONE : i_dbc_num;
        single     = (n_req == CNT_ONE);
        // Saturating increment: the counter never wraps back to a small value.
        cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;
        ov_hit     = i_adc_data > i_ovp_th;
        uv_hit     = i_adc_data < i_uvp_th;
        ov_rls_hit = i_adc_data < i_ovp_rls_th;
        uv_rls_hit = i_adc_data > i_uvp_rls_th;
    end

    // Next-state logic. The ">= n_req" tests (rather than "==") make a
    // debounce count lowered mid-debounce take effect on the next sample,
    // instead of leaving a saturated counter stuck in a pending state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!i_flt_en) begin
            state_d = NORM;
            cnt_d   = '0;
        end else if (i_adc_vld) begin
            unique case (state_q)
                NORM: begin
                    if (ov_hit) begin
                        state_d = single ? OV_FLT : OV_PEND;
                        cnt_d   = single ? '0 : CNT_ONE;
                    end else if (uv_hit) begin
                        state_d = single ? UV_FLT : UV_PEND;
                        cnt_d   = single ? '0 : CNT_ONE;
                    end
                end
                OV_PEND: begin
                    if (!ov_hit) begin
                        state_d = NORM;
                        cnt_d   = '0;
                    end else if (cnt_inc >= n_req) begin
                        state_d = OV_FLT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_inc;
                    end
                end
                OV_FLT: begin
                    if (ov_rls_hit) begin
                        state_d = single ? NORM : OV_RLS;
                        cnt_d   = single ? '0 : CNT_ONE;
                    end
                end
                OV_RLS: begin
                    if (!ov_rls_hit) begin
                        state_d = OV_FLT;
                        cnt_d   = '0;
                    end else if (cnt_inc >= n_req) begin
                        state_d = NORM;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_inc;
                    end
                end
                UV_PEND: begin
                    if (!uv_hit) begin
                        state_d = NORM;
                        cnt_d   = '0;
                    end else if (cnt_inc >= n_req) begin
                        state_d = UV_FLT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_inc;
                    end
                end
                UV_FLT: begin
                    if (uv_rls_hit) begin
                        state_d = single ? NORM : UV_RLS;
                        cnt_d   = single ? '0 : CNT_ONE;
                    end
                end
                UV_RLS: begin
                    if (!uv_rls_hit) begin
                        state_d = UV_FLT;
                        cnt_d   = '0;
                    end else if (cnt_inc >= n_req) begin
                        state_d = NORM;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_inc;
                    end
                end
                default: begin
                    state_d = NORM;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Flags and sticky bits are decoded from the next state so they line up
    // with state_q, one cycle after the accepting edge. Sticky bits only set
    // on a fresh trip; a bounce OV_RLS -> OV_FLT is not a new fault.
    always_comb begin
        ovp_flt_d    = (state_d == OV_FLT) || (state_d == OV_RLS);
        uvp_flt_d    = (state_d == UV_FLT) || (state_d == UV_RLS);
        ov_trip      = (state_d == OV_FLT) && ((state_q == NORM) || (state_q == OV_PEND));
        uv_trip      = (state_d == UV_FLT) && ((state_q == NORM) || (state_q == UV_PEND));
        ovp_sticky_d = ov_trip ? 1'b1 : (i_flt_clr ? 1'b0 : ovp_sticky_q);
        uvp_sticky_d = uv_trip ? 1'b1 : (i_flt_clr ? 1'b0 : uvp_sticky_q);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= NORM;
            cnt_q        <= '0;
            ovp_flt_q    <= 1'b0;
            uvp_flt_q    <= 1'b0;
            ovp_sticky_q <= 1'b0;
            uvp_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ovp_flt_q    <= ovp_flt_d;
            uvp_flt_q    <= uvp_flt_d;
            ovp_sticky_q <= ovp_sticky_d;
            uvp_sticky_q <= uvp_sticky_d;
        end
    end

    assign o_ovp_flt    = ovp_flt_q;
    assign o_uvp_flt    = uvp_flt_q;
    assign o_ovp_sticky = ovp_sticky_q;
    assign o_uvp_sticky = uvp_sticky_q;

`ifdef HV_ADC_FLT_MIN_MAX_EN
    logic [ADC_DW-1:0] data_max_q, data_max_d;
    logic [ADC_DW-1:0] data_min_q, data_min_d;

    // A clear in the same cycle as a sample wins; that sample is dropped.
    always_comb begin
        data_max_d = data_max_q;
        data_min_d = data_min_q;
        if (i_flt_clr) begin
            data_max_d = '0;
            data_min_d = '1;
        end else if (i_adc_vld && i_flt_en) begin
            if (i_adc_data > data_max_q) data_max_d = i_adc_data;
            if (i_adc_data < data_min_q) data_min_d = i_adc_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            data_max_q <= '0;
            data_min_q <= '1;
        end else begin
            data_max_q <= data_max_d;
            data_min_q <= data_min_d;
        end
    end

    assign o_data_max = data_max_q;
    assign o_data_min = data_min_q;
`else
    assign o_data_max = '0;
    assign o_data_min = '1;
`endif

endmodule

// File: tb/tb_hv_adc_flt_chk.sv
// ---------------------------------------------------------------------------
// tb_hv_adc_flt_chk
//
// Directed bench for hv_adc_flt_chk. Inputs are driven on the falling edge
// and outputs are sampled on the following falling edge, so every sample
// strobe is seen by exactly one rising edge. FSM state and debounce counter
// are observed through dut.state_q / dut.cnt_q.
// ---------------------------------------------------------------------------
module tb_hv_adc_flt_chk;

    localparam int ADC_DW = 10;
    localparam int DBC_DW = 4;

    localparam logic [2:0] S_NORM    = 3'd0;
    localparam logic [2:0] S_OV_PEND = 3'd1;
    localparam logic [2:0] S_OV_FLT  = 3'd2;
    localparam logic [2:0] S_OV_RLS  = 3'd3;
    localparam logic [2:0] S_UV_PEND = 3'd4;
    localparam logic [2:0] S_UV_FLT  = 3'd5;

    logic              clk;
    logic              rst;
    logic [ADC_DW-1:0] adc_data;
    logic              adc_vld;
    logic              flt_en;
    logic [ADC_DW-1:0] ovp_th, ovp_rls_th, uvp_th, uvp_rls_th;
    logic [DBC_DW-1:0] dbc_num;
    logic              flt_clr;
    logic              ovp_flt, uvp_flt, ovp_sticky, uvp_sticky;
    logic [ADC_DW-1:0] data_max, data_min;

    int vec_cnt = 0;
    int err_cnt = 0;

    hv_adc_flt_chk #(.ADC_DW(ADC_DW), .DBC_DW(DBC_DW)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_adc_data   (adc_data),
        .i_adc_vld    (adc_vld),
        .i_flt_en     (flt_en),
        .i_ovp_th     (ovp_th),
        .i_ovp_rls_th (ovp_rls_th),
        .i_uvp_th     (uvp_th),
        .i_uvp_rls_th (uvp_rls_th),
        .i_dbc_num    (dbc_num),
        .i_flt_clr    (flt_clr),
        .o_ovp_flt    (ovp_flt),
        .o_uvp_flt    (uvp_flt),
        .o_ovp_sticky (ovp_sticky),
        .o_uvp_sticky (uvp_sticky),
        .o_data_max   (data_max),
        .o_data_min   (data_min)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic send(input logic [ADC_DW-1:0] d, input logic clr);
        @(negedge clk);
        adc_data = d;
        adc_vld  = 1'b1;
        flt_clr  = clr;
        @(negedge clk);
        adc_vld  = 1'b0;
        flt_clr  = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        flt_clr = 1'b1;
        @(negedge clk);
        flt_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; adc_data = '0; adc_vld = 1'b0; flt_en = 1'b1; flt_clr = 1'b0;
        ovp_th = 10'd800; ovp_rls_th = 10'd750; uvp_th = 10'd100; uvp_rls_th = 10'd150;
        dbc_num = 4'd3;
        repeat (2) @(negedge clk);
        vec_cnt++; if (dut.state_q !== S_NORM) begin err_cnt++; $display("FAIL rst_state: got %0d want 0", dut.state_q); end
        vec_cnt++; if (dut.cnt_q !== 4'd0) begin err_cnt++; $display("FAIL rst_cnt: got %0d want 0", dut.cnt_q); end
        vec_cnt++; if ({ovp_flt, uvp_flt, ovp_sticky, uvp_sticky} !== 4'b0000) begin err_cnt++; $display("FAIL rst_flags: got %b want 0000", {ovp_flt, uvp_flt, ovp_sticky, uvp_sticky}); end
        vec_cnt++; if (data_max !== 10'd0) begin err_cnt++; $display("FAIL rst_max: got %0d want 0", data_max); end
        vec_cnt++; if (data_min !== 10'h3FF) begin err_cnt++; $display("FAIL rst_min: got %0d want 1023", data_min); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_trip_release();
        dbc_num = 4'd3;
        send(10'd801, 1'b0);
        vec_cnt++; if (dut.state_q !== S_OV_PEND || dut.cnt_q !== 4'd1) begin err_cnt++; $display("FAIL trip_s1: got state %0d cnt %0d want 1/1", dut.state_q, dut.cnt_q); end
        vec_cnt++; if (ovp_flt !== 1'b0) begin err_cnt++; $display("FAIL trip_flt1: got %b want 0", ovp_flt); end
        send(10'd805, 1'b0);
        vec_cnt++; if (ovp_flt !== 1'b0 || dut.cnt_q !== 4'd2) begin err_cnt++; $display("FAIL trip_s2: got flt %b cnt %0d want 0/2", ovp_flt, dut.cnt_q); end
        send(10'd810, 1'b0);
        vec_cnt++; if (ovp_flt !== 1'b1) begin err_cnt++; $display("FAIL trip_flt3: got %b want 1", ovp_flt); end
        vec_cnt++; if (ovp_sticky !== 1'b1) begin err_cnt++; $display("FAIL trip_sticky: got %b want 1", ovp_sticky); end
        vec_cnt++; if (dut.state_q !== S_OV_FLT || dut.cnt_q !== 4'd0) begin err_cnt++; $display("FAIL trip_state: got %0d cnt %0d want 2/0", dut.state_q, dut.cnt_q); end
        send(10'd749, 1'b0);
        vec_cnt++; if (ovp_flt !== 1'b1 || dut.state_q !== S_OV_RLS) begin err_cnt++; $display("FAIL rls_s1: got flt %b state %0d want 1/3", ovp_flt, dut.state_q); end
        send(10'd749, 1'b0);
        vec_cnt++; if (ovp_flt !== 1'b1) begin err_cnt++; $display("FAIL rls_s2: got %b want 1", ovp_flt); end
        send(10'd749, 1'b0);
        vec_cnt++; if (ovp_flt !== 1'b0 || dut.state_q !== S_NORM) begin err_cnt++; $display("FAIL rls_s3: got flt %b state %0d want 0/0", ovp_flt, dut.state_q); end
        vec_cnt++; if (ovp_sticky !== 1'b1) begin err_cnt++; $display("FAIL rls_sticky: got %b want 1", ovp_sticky); end
    endtask

    task automatic test_debounce_break();
        logic [ADC_DW-1:0] seq [5];
        seq = '{10'd90, 10'd90, 10'd90, 10'd120, 10'd90};
        dbc_num = 4'd4;
        for (int i = 0; i < 5; i++) begin
            send(seq[i], 1'b0);
            vec_cnt++; if (uvp_flt !== 1'b0) begin err_cnt++; $display("FAIL dbc_brk_flt%0d: got %b want 0", i, uvp_flt); end
            if (i == 3) begin
                vec_cnt++; if (dut.state_q !== S_NORM || dut.cnt_q !== 4'd0) begin err_cnt++; $display("FAIL dbc_brk_norm: got %0d cnt %0d want 0/0", dut.state_q, dut.cnt_q); end
            end
        end
        vec_cnt++; if (dut.state_q !== S_UV_PEND || dut.cnt_q !== 4'd1) begin err_cnt++; $display("FAIL dbc_brk_end: got %0d cnt %0d want 4/1", dut.state_q, dut.cnt_q); end
        send(10'd120, 1'b0);
    endtask

    task automatic test_hysteresis();
        dbc_num = 4'd2;
        send(10'd850, 1'b0);
        send(10'd850, 1'b0);
        vec_cnt++; if (ovp_flt !== 1'b1) begin err_cnt++; $display("FAIL hys_trip: got %b want 1", ovp_flt); end
        send(10'd760, 1'b0);
        vec_cnt++; if (ovp_flt !== 1'b1 || dut.state_q !== S_OV_FLT) begin err_cnt++; $display("FAIL hys_760a: got flt %b state %0d want 1/2", ovp_flt, dut.state_q); end
        send(10'd740, 1'b0);
        vec_cnt++; if (ovp_flt !== 1'b1 || dut.state_q !== S_OV_RLS) begin err_cnt++; $display("FAIL hys_740: got flt %b state %0d want 1/3", ovp_flt, dut.state_q); end
        send(10'd760, 1'b0);
        vec_cnt++; if (ovp_flt !== 1'b1 || dut.state_q !== S_OV_FLT || dut.cnt_q !== 4'd0) begin err_cnt++; $display("FAIL hys_760b: got flt %b state %0d cnt %0d want 1/2/0", ovp_flt, dut.state_q, dut.cnt_q); end
        send(10'd700, 1'b0);
        send(10'd700, 1'b0);
        vec_cnt++; if (ovp_flt !== 1'b0 || dut.state_q !== S_NORM) begin err_cnt++; $display("FAIL hys_rls: got flt %b state %0d want 0/0", ovp_flt, dut.state_q); end
    endtask

    task automatic test_dbc_zero_one();
        for (int k = 0; k < 2; k++) begin
            dbc_num = 4'(k);
            send(10'd900, 1'b0);
            vec_cnt++; if (ovp_flt !== 1'b1 || dut.state_q !== S_OV_FLT) begin err_cnt++; $display("FAIL dbc%0d_trip: got flt %b state %0d want 1/2", k, ovp_flt, dut.state_q); end
            send(10'd700, 1'b0);
            vec_cnt++; if (ovp_flt !== 1'b0 || dut.state_q !== S_NORM) begin err_cnt++; $display("FAIL dbc%0d_rls: got flt %b state %0d want 0/0", k, ovp_flt, dut.state_q); end
        end
    endtask

    task automatic test_clr_set();
        dbc_num = 4'd2;
        pulse_clr();
        vec_cnt++; if (ovp_sticky !== 1'b0) begin err_cnt++; $display("FAIL clr_ovp_sticky: got %b want 0", ovp_sticky); end
        send(10'd90, 1'b0);
        send(10'd90, 1'b1);
        vec_cnt++; if (uvp_flt !== 1'b1 || dut.state_q !== S_UV_FLT) begin err_cnt++; $display("FAIL clrset_flt: got flt %b state %0d want 1/5", uvp_flt, dut.state_q); end
        vec_cnt++; if (uvp_sticky !== 1'b1) begin err_cnt++; $display("FAIL clrset_sticky: got %b want 1", uvp_sticky); end
        pulse_clr();
        vec_cnt++; if (uvp_sticky !== 1'b0) begin err_cnt++; $display("FAIL lone_clr_sticky: got %b want 0", uvp_sticky); end
        vec_cnt++; if (uvp_flt !== 1'b1 || dut.state_q !== S_UV_FLT) begin err_cnt++; $display("FAIL lone_clr_flt: got flt %b state %0d want 1/5", uvp_flt, dut.state_q); end
    endtask

    task automatic test_disable();
        @(negedge clk); flt_en = 1'b0;
        @(negedge clk);
        vec_cnt++; if (uvp_flt !== 1'b0 || dut.state_q !== S_NORM) begin err_cnt++; $display("FAIL dis_uv: got flt %b state %0d want 0/0", uvp_flt, dut.state_q); end
        flt_en = 1'b1; dbc_num = 4'd1;
        send(10'd900, 1'b0);
        vec_cnt++; if (ovp_flt !== 1'b1 || ovp_sticky !== 1'b1) begin err_cnt++; $display("FAIL dis_pre: got flt %b sticky %b want 1/1", ovp_flt, ovp_sticky); end
        @(negedge clk); flt_en = 1'b0;
        @(negedge clk);
        vec_cnt++; if (ovp_flt !== 1'b0 || dut.state_q !== S_NORM) begin err_cnt++; $display("FAIL dis_ov: got flt %b state %0d want 0/0", ovp_flt, dut.state_q); end
        vec_cnt++; if (ovp_sticky !== 1'b1) begin err_cnt++; $display("FAIL dis_sticky_held: got %b want 1", ovp_sticky); end
        send(10'd900, 1'b0);
        vec_cnt++; if (ovp_flt !== 1'b0 || dut.state_q !== S_NORM) begin err_cnt++; $display("FAIL dis_ignore: got flt %b state %0d want 0/0", ovp_flt, dut.state_q); end
        pulse_clr();
        vec_cnt++; if (ovp_sticky !== 1'b0) begin err_cnt++; $display("FAIL dis_clr: got %b want 0", ovp_sticky); end
        flt_en = 1'b1; dbc_num = 4'd2;
        send(10'd900, 1'b0);
        vec_cnt++; if (dut.state_q !== S_OV_PEND || dut.cnt_q !== 4'd1 || ovp_flt !== 1'b0) begin err_cnt++; $display("FAIL reen: got state %0d cnt %0d flt %b want 1/1/0", dut.state_q, dut.cnt_q, ovp_flt); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        vec_cnt++; if (dut.state_q !== S_NORM || dut.cnt_q !== 4'd0) begin err_cnt++; $display("FAIL arst_state: got %0d cnt %0d want 0/0", dut.state_q, dut.cnt_q); end
        vec_cnt++; if ({ovp_flt, uvp_flt, ovp_sticky, uvp_sticky} !== 4'b0000) begin err_cnt++; $display("FAIL arst_flags: got %b want 0000", {ovp_flt, uvp_flt, ovp_sticky, uvp_sticky}); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_min_max();
        send(10'd300, 1'b0);
        send(10'd700, 1'b0);
        send(10'd200, 1'b0);
`ifdef HV_ADC_FLT_MIN_MAX_EN
        vec_cnt++; if (data_max !== 10'd700) begin err_cnt++; $display("FAIL mm_max: got %0d want 700", data_max); end
        vec_cnt++; if (data_min !== 10'd200) begin err_cnt++; $display("FAIL mm_min: got %0d want 200", data_min); end
        send(10'd500, 1'b1);
        vec_cnt++; if (data_max !== 10'd0 || data_min !== 10'h3FF) begin err_cnt++; $display("FAIL mm_clr: got %0d/%0d want 0/1023", data_max, data_min); end
        send(10'd400, 1'b0);
        vec_cnt++; if (data_max !== 10'd400 || data_min !== 10'd400) begin err_cnt++; $display("FAIL mm_after: got %0d/%0d want 400/400", data_max, data_min); end
`else
        vec_cnt++; if (data_max !== 10'd0 || data_min !== 10'h3FF) begin err_cnt++; $display("FAIL mm_tied: got %0d/%0d want 0/1023", data_max, data_min); end
`endif
    endtask

    initial begin
        test_reset();
        test_trip_release();
        test_debounce_break();
        test_hysteresis();
        test_dbc_zero_one();
        test_clr_set();
        test_disable();
        test_async_reset();
        test_min_max();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/hv_adc_flt_chk.md
Name: hv_adc_flt_chk

Overview:
Downstream consumer of the averaged HV ADC sample (4-sample mean per channel). It compares each accepted averaged sample against programmable over/under thresholds, applying hysteresis and consecutive-sample debounce. It raises live OVP/UVP fault flags and sticky status bits for the HV protection/status logic. One instance per ADC channel.

Parameters:
ADC_DW, 10, width of averaged ADC data and all thresholds
DBC_DW, 4, width of debounce count configuration and internal counter

Ports:
i_clk  input  1  clock; the block uses this single clock
i_rst  input  1  asynchronous, active-high reset
i_adc_data  input  ADC_DW  averaged ADC sample, unsigned
i_adc_vld  input  1  one-cycle strobe; i_adc_data is accepted only when high
i_flt_en  input  1  checker enable, level
i_ovp_th  input  ADC_DW  OV trip threshold; trips when data > th
i_ovp_rls_th  input  ADC_DW  OV release threshold; releases when data < th
i_uvp_th  input  ADC_DW  UV trip threshold; trips when data < th
i_uvp_rls_th  input  ADC_DW  UV release threshold; releases when data > th
i_dbc_num  input  DBC_DW  required consecutive samples; 0 is treated as 1
i_flt_clr  input  1  one-cycle pulse; clears sticky bits
o_ovp_flt  output  1  live OV fault
o_uvp_flt  output  1  live UV fault
o_ovp_sticky  output  1  latched OV fault seen
o_uvp_sticky  output  1  latched UV fault seen
o_data_max  output  ADC_DW  max accepted sample (optional feature)
o_data_min  output  ADC_DW  min accepted sample (optional feature)

Behaviour:
- Reset: FSM=NORM, debounce counter=0, all flags/sticky=0, o_data_max=0, o_data_min=all-ones.
- FSM states: NORM, OV_PEND, OV_FLT, OV_RLS, UV_PEND, UV_FLT, UV_RLS. The FSM advances only on cycles with i_adc_vld=1. Cycles without a strobe hold state and counter.
- Let N = max(i_dbc_num, 1). The counter (cnt) counts consecutive qualifying samples and saturates at all-ones.
- NORM:
  - data > ovp_th: go to OV_PEND with cnt=1.
  - else data < uvp_th: go to UV_PEND with cnt=1.
  - OV has priority if both conditions hold (misconfigured thresholds).
  - If N=1, go directly to OV_FLT/UV_FLT instead.
- OV_PEND:
  - Qualifying sample: cnt+1. When cnt+1 == N, go to OV_FLT and clear cnt.
  - Non-qualifying sample: go to NORM, cnt=0.
- OV_FLT:
  - data < ovp_rls_th: go to OV_RLS with cnt=1 (or NORM if N=1).
- OV_RLS:
  - data < ovp_rls_th: cnt+1. When it reaches N, go to NORM.
  - Otherwise: back to OV_FLT, cnt=0.
- UV_PEND/UV_FLT/UV_RLS mirror the OV states with the UV conditions.
- o_ovp_flt=1 in OV_FLT and OV_RLS. o_uvp_flt=1 in UV_FLT and UV_RLS. Flags are registered.
- Latency: a flag rises on the cycle after the clock edge that accepts the N-th consecutive qualifying sample. It falls on the same kind of edge for the N-th release sample.
- Sticky bits:
  - Set on entry to OV_FLT/UV_FLT.
  - Cleared by i_flt_clr.
  - If a set and a clear occur in the same cycle, set wins.
  - i_flt_clr does not affect the live flags or the FSM.
- i_flt_en=0: synchronously force NORM, cnt=0, live flags=0. Sticky bits are held, and i_flt_clr still works. Re-enabling starts the debounce from zero.
- Threshold or i_dbc_num changes mid-debounce apply from the next accepted sample. There is no counter restart.
- Reset asserted mid-operation returns all state to reset values immediately (asynchronous).

Optional Feature:
- Macro: HV_ADC_FLT_MIN_MAX_EN.
- Defined:
  - On each accepted sample with i_flt_en=1, o_data_max = max(o_data_max, data) and o_data_min = min(o_data_min, data). Both are registered.
  - i_flt_clr reloads max=0 and min=all-ones. If a clear and a sample arrive in the same cycle, the clear wins and the sample is discarded for min/max.
- Undefined: o_data_max ties to 0 and o_data_min ties to all-ones, with no registers inferred.

Test Plan:
1. Trip and release: ovp_th=800, ovp_rls_th=750, dbc=3. Samples 801,805,810 -> o_ovp_flt rises after the 3rd strobe, o_ovp_sticky=1. Then 749×3 -> o_ovp_flt falls after the 3rd strobe; sticky stays 1.
2. Debounce break: uvp_th=100, dbc=4. Samples 90,90,90,120,90 -> no UV fault; FSM back in NORM after 120, cnt=1 after the final 90.
3. Hysteresis: OV fault active, ovp_rls_th=750. Samples 760,740,760 -> flag stays 1 throughout; FSM goes OV_RLS then back to OV_FLT.
4. dbc=0 and 1 both trip on the first sample of 900 with ovp_th=800.
5. Simultaneous clear and set: i_flt_clr pulsed on the same edge the FSM enters UV_FLT -> o_uvp_sticky=1. A later lone clear -> 0 while o_uvp_flt remains 1.
6. Disable and async reset: i_flt_en=0 while in OV_FLT -> flag 0 next cycle, sticky held. Assert i_rst mid-OV_PEND -> all outputs at reset values immediately. With HV_ADC_FLT_MIN_MAX_EN, samples 300,700,200 -> max=700, min=200.
